timer_ctrl: RTL and testbench

- Control-side initiator for the 8-bit timer counter. Drives the counter's control inputs (clk_ena, start_counter, up_down, load, enable) and consumes its overflow/underflow flags.
- Acknowledges each flag with a one-cycle clear pulse, latches the events into sticky software status and raises an interrupt.
- Sits between the register file (cfg_*/cmd_*/sw_* inputs) and the counter instance.

---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_prescaler.sv | 43 ++++
 rtl/timer_ctrl.sv | 114 +++++++++++
 tb/tb_timer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants, state encoding and prescaler mask helper for timer_ctrl
package timer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DIV_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_CLR  = 2'd3
    } state_t;

    // Low div bits set: clk_ena fires when the prescaler matches this mask.
    function automatic logic [31:0] presc_mask(input int div);
        return (32'd1 << div) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running prescaler producing the next-cycle count qualifier
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             clk_ena
);

    localparam int PW = (1 << DIV_W) - 1;

    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_next;
    logic [PW-1:0] mask;
    logic [31:0]   mask_full;

    // clk_ena describes the cycle that cnt_next belongs to, so the parent can register it.
    always_comb begin
        mask_full = presc_mask(int'(div));
        mask      = mask_full[PW-1:0];
        cnt_next  = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (run) begin
            cnt_next = cnt + PW'(1);
        end
        clk_ena = run && ((cnt_next & mask) == mask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - control-side initiator for the 8-bit timer counter with flag acknowledge and irq
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_enable,
    input  logic             cfg_up_down,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_auto_reload,
    input  logic             cfg_ovf_ie,
    input  logic             cfg_udf_ie,
    input  logic             cmd_load,
    input  logic             sw_clr_ovf,
    input  logic             sw_clr_udf,
    input  logic             overflow,
    input  logic             underflow,
    output logic             clk_ena,
    output logic [WIDTH-1:0] start_counter,
    output logic             up_down,
    output logic             load,
    output logic             enable,
    output logic             clr_overflow,
    output logic             clr_underflow,
    output logic             sts_ovf,
    output logic             sts_udf,
    output logic             irq
);

    state_t state;
    state_t state_next;
    logic   flag;
    logic   presc_clear;
    logic   presc_run;
    logic   presc_ena;

    always_comb begin
        state_next = state;
        flag       = overflow | underflow;
        unique case (state)
            ST_IDLE: begin
                if (flag)            state_next = ST_CLR;
                else if (cmd_load)   state_next = ST_LOAD;
                else if (cfg_enable) state_next = ST_RUN;
            end
            ST_LOAD: begin
                state_next = cfg_enable ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (flag)             state_next = ST_CLR;
                else if (cmd_load)    state_next = ST_LOAD;
                else if (!cfg_enable) state_next = ST_IDLE;
            end
            ST_CLR: begin
                if (cfg_auto_reload) state_next = ST_LOAD;
                else if (cfg_enable) state_next = ST_RUN;
                else                 state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        presc_run   = (state_next == ST_RUN);
        presc_clear = presc_run && (state != ST_RUN);
    end

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (presc_clear),
        .run     (presc_run),
        .div     (cfg_div),
        .clk_ena (presc_ena)
    );

    // Outputs are registered from state_next so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            clk_ena       <= 1'b0;
            start_counter <= '0;
            up_down       <= 1'b0;
            load          <= 1'b0;
            enable        <= 1'b0;
            clr_overflow  <= 1'b0;
            clr_underflow <= 1'b0;
            sts_ovf       <= 1'b0;
            sts_udf       <= 1'b0;
            irq           <= 1'b0;
        end else begin
            state         <= state_next;
            load          <= (state_next == ST_LOAD);
            enable        <= (state_next == ST_RUN);
            clk_ena       <= (state_next == ST_LOAD) | presc_ena;
            up_down       <= cfg_up_down;
            clr_overflow  <= (state_next == ST_CLR) & overflow;
            clr_underflow <= (state_next == ST_CLR) & underflow;
            if (state_next == ST_LOAD) begin
                start_counter <= cfg_start;
            end
            // A set coinciding with a software clear must win.
            if (clr_overflow)    sts_ovf <= 1'b1;
            else if (sw_clr_ovf) sts_ovf <= 1'b0;
            if (clr_underflow)   sts_udf <= 1'b1;
            else if (sw_clr_udf) sts_udf <= 1'b0;
            irq <= (sts_ovf & cfg_ovf_ie) | (sts_udf & cfg_udf_ie);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl with a behavioural counter/controller model
module tb_timer_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_CLR  = 3;

    logic       clk = 1'b0;
    logic       rst_n, cfg_enable, cfg_up_down, cfg_auto_reload, cfg_ovf_ie, cfg_udf_ie;
    logic [7:0] cfg_start;
    logic [1:0] cfg_div;
    logic       cmd_load, sw_clr_ovf, sw_clr_udf, overflow, underflow;
    logic       clk_ena, up_down, load, enable, clr_overflow, clr_underflow;
    logic       sts_ovf, sts_udf, irq;
    logic [7:0] start_counter;

    always #5 clk = ~clk;

    timer_ctrl #(.WIDTH(8), .DIV_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_enable      (cfg_enable),
        .cfg_up_down     (cfg_up_down),
        .cfg_start       (cfg_start),
        .cfg_div         (cfg_div),
        .cfg_auto_reload (cfg_auto_reload),
        .cfg_ovf_ie      (cfg_ovf_ie),
        .cfg_udf_ie      (cfg_udf_ie),
        .cmd_load        (cmd_load),
        .sw_clr_ovf      (sw_clr_ovf),
        .sw_clr_udf      (sw_clr_udf),
        .overflow        (overflow),
        .underflow       (underflow),
        .clk_ena         (clk_ena),
        .start_counter   (start_counter),
        .up_down         (up_down),
        .load            (load),
        .enable          (enable),
        .clr_overflow    (clr_overflow),
        .clr_underflow   (clr_underflow),
        .sts_ovf         (sts_ovf),
        .sts_udf         (sts_udf),
        .irq             (irq)
    );

    typedef struct packed {
        logic       clk_ena;
        logic [7:0] start;
        logic       up;
        logic       load;
        logic       enable;
        logic       clr_o;
        logic       clr_u;
        logic       sts_o;
        logic       sts_u;
        logic       irq;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   ms;
    int   run_idx;
    logic f_ovf, f_udf, ev_ovf, ev_udf;
    int   errors = 0;
    int   checks = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: predict the outputs after the coming edge, then advance the counter's flag model.
    task automatic step();
        exp_t n;
        int   ns;
        int   nrun;
        int   per;
        n    = '0;
        ns   = M_IDLE;
        nrun = 0;
        if (rst_n) begin
            case (ms)
                M_IDLE:  ns = (f_ovf | f_udf) ? M_CLR : cmd_load ? M_LOAD : cfg_enable ? M_RUN : M_IDLE;
                M_LOAD:  ns = cfg_enable ? M_RUN : M_IDLE;
                M_RUN:   ns = (f_ovf | f_udf) ? M_CLR : cmd_load ? M_LOAD : !cfg_enable ? M_IDLE : M_RUN;
                default: ns = cfg_auto_reload ? M_LOAD : cfg_enable ? M_RUN : M_IDLE;
            endcase
            nrun      = (ns == M_RUN) ? ((ms == M_RUN) ? run_idx + 1 : 0) : run_idx;
            per       = 1 << cfg_div;
            n.load    = (ns == M_LOAD);
            n.enable  = (ns == M_RUN);
            n.clk_ena = (ns == M_LOAD) || ((ns == M_RUN) && ((nrun % per) == per - 1));
            n.start   = (ns == M_LOAD) ? cfg_start : cur.start;
            n.up      = cfg_up_down;
            n.clr_o   = (ns == M_CLR) && f_ovf;
            n.clr_u   = (ns == M_CLR) && f_udf;
            n.sts_o   = cur.clr_o ? 1'b1 : sw_clr_ovf ? 1'b0 : cur.sts_o;
            n.sts_u   = cur.clr_u ? 1'b1 : sw_clr_udf ? 1'b0 : cur.sts_u;
            n.irq     = (cur.sts_o & cfg_ovf_ie) | (cur.sts_u & cfg_udf_ie);
        end
        q.push_back(n);
        @(negedge clk);
        f_ovf      = (f_ovf & ~cur.clr_o) | ev_ovf;
        f_udf      = (f_udf & ~cur.clr_u) | ev_udf;
        ev_ovf     = 1'b0;
        ev_udf     = 1'b0;
        cur        = n;
        ms         = ns;
        run_idx    = nrun;
        cmd_load   = 1'b0;
        sw_clr_ovf = 1'b0;
        sw_clr_udf = 1'b0;
        overflow   = f_ovf;
        underflow  = f_udf;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk1("load", load, e.load);
                chk1("enable", enable, e.enable);
                chk1("clk_ena", clk_ena, e.clk_ena);
                chk8("start_counter", start_counter, e.start);
                chk1("clr_overflow", clr_overflow, e.clr_o);
                chk1("clr_underflow", clr_underflow, e.clr_u);
                chk1("sts_ovf", sts_ovf, e.sts_o);
                chk1("sts_udf", sts_udf, e.sts_u);
                chk1("irq", irq, e.irq);
                if (e.enable) chk1("up_down", up_down, e.up);
            end
        end
    end

    initial begin
        rst_n = 1'b0; cfg_enable = 1'b0; cfg_up_down = 1'b0; cfg_start = 8'h00; cfg_div = 2'd0;
        cfg_auto_reload = 1'b0; cfg_ovf_ie = 1'b0; cfg_udf_ie = 1'b0;
        cmd_load = 1'b0; sw_clr_ovf = 1'b0; sw_clr_udf = 1'b0; overflow = 1'b0; underflow = 1'b0;
        f_ovf = 1'b0; f_udf = 1'b0; ev_ovf = 1'b0; ev_udf = 1'b0;
        cur = '0; ms = M_IDLE; run_idx = 0;

        repeat (5) step();
        rst_n = 1'b1;
        repeat (2) step();

        cfg_start = 8'hF0; cfg_enable = 1'b1; cfg_div = 2'd0; cfg_up_down = 1'b1; cmd_load = 1'b1;
        step();
        repeat (6) step();

        cfg_enable = 1'b0;
        repeat (2) step();
        cfg_div = 2'd2; cfg_enable = 1'b1;
        repeat (12) step();
        cfg_enable = 1'b0;
        step();
        cfg_div = 2'd3; cfg_enable = 1'b1;
        repeat (20) step();

        cfg_div = 2'd0; cfg_ovf_ie = 1'b1; cfg_udf_ie = 1'b1; cfg_auto_reload = 1'b0; ev_ovf = 1'b1;
        repeat (6) step();
        sw_clr_ovf = 1'b1;
        repeat (4) step();

        cfg_auto_reload = 1'b1; cfg_start = 8'h3C; ev_ovf = 1'b1; ev_udf = 1'b1;
        repeat (6) step();
        cfg_auto_reload = 1'b0; sw_clr_ovf = 1'b1; sw_clr_udf = 1'b1;
        repeat (3) step();

        ev_udf = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sw_clr_udf = (ms == M_CLR);
            step();
        end
        sw_clr_udf = 1'b1;
        repeat (2) step();

        ev_ovf = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rst_n = (ms != M_CLR);
            step();
        end
        rst_n = 1'b1;
        repeat (6) step();

        for (int i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            cmd_load   = ($urandom_range(0, 9) == 0);
            sw_clr_ovf = ($urandom_range(0, 5) == 0);
            sw_clr_udf = ($urandom_range(0, 5) == 0);
            ev_ovf     = ($urandom_range(0, 24) == 0);
            ev_udf     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 39) == 0) cfg_div = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) cfg_up_down = ~cfg_up_down;
            if ($urandom_range(0, 49) == 0) cfg_auto_reload = ~cfg_auto_reload;
            if ($urandom_range(0, 29) == 0) cfg_ovf_ie = ~cfg_ovf_ie;
            if ($urandom_range(0, 29) == 0) cfg_udf_ie = ~cfg_udf_ie;
            cfg_start = 8'($urandom_range(0, 255));
            step();
        end
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
